// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single read/write port of the program/data RAM.
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN.
//
// state  | meaning
// IDLE   | waiting for a request; winner's gnt driven combinationally
// ACCESS | ram_en high for one cycle, read data captured on exit
// DONE   | winner's done pulse visible, no grants

module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_done,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_done,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t                state_q, state_d;
   logic                  sel_q, sel_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  m0_done_q, m0_done_d;
   logic                  m1_done_q, m1_done_d;
   logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
`ifdef RAM_ARB_RR_EN
   logic                  last_q, last_d;
`endif

   logic any_req;
   logic pick1;
   logic grant_ok;

   // Arbitration: pick1 selects port 1 as the winner of this IDLE cycle.
   always_comb begin
      any_req  = m0_req | m1_req;
`ifdef RAM_ARB_RR_EN
      pick1    = m1_req & (~m0_req | ~last_q);
`else
      pick1    = m1_req & (~m0_req | (wait_cnt_q == MAX_WAIT_C));
`endif
      grant_ok = (state_q == ST_IDLE) & ~rst;
      m0_gnt   = grant_ok & m0_req & ~pick1;
      m1_gnt   = grant_ok & pick1;
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      m0_done_d   = 1'b0;
      m1_done_d   = 1'b0;
      m0_rdata_d  = m0_rdata_q;
      m1_rdata_d  = m1_rdata_q;
`ifdef RAM_ARB_RR_EN
      last_d      = last_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               ram_en_d    = 1'b1;
               ram_we_d    = pick1 ? m1_we    : m0_we;
               ram_addr_d  = pick1 ? m1_addr  : m0_addr;
               ram_wdata_d = pick1 ? m1_wdata : m0_wdata;
               sel_d       = pick1;
               state_d     = ST_ACCESS;
`ifdef RAM_ARB_RR_EN
               last_d      = pick1;
`endif
            end
         end
         ST_ACCESS: begin
            if (sel_q) begin
               m1_done_d = 1'b1;
               if (!ram_we_q) m1_rdata_d = ram_rdata;
            end else begin
               m0_done_d = 1'b1;
               if (!ram_we_q) m0_rdata_d = ram_rdata;
            end
            ram_en_d = 1'b0;
            ram_we_d = 1'b0;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Aging counter for port 1; only advances while port 1 is denied in IDLE.
   always_comb begin
`ifdef RAM_ARB_RR_EN
      wait_cnt_d = 4'd0;
`else
      wait_cnt_d = wait_cnt_q;
      if (!m1_req || m1_gnt) begin
         wait_cnt_d = 4'd0;
      end else if ((state_q == ST_IDLE) && (wait_cnt_q < MAX_WAIT_C)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= 1'b0;
         wait_cnt_q  <= 4'd0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         m0_done_q   <= 1'b0;
         m1_done_q   <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
`ifdef RAM_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         wait_cnt_q  <= wait_cnt_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         m0_done_q   <= m0_done_d;
         m1_done_q   <= m1_done_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
`ifdef RAM_ARB_RR_EN
         last_q      <= last_d;
`endif
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign m0_done   = m0_done_q;
   assign m1_done   = m1_done_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RAM model, grant/access/done scoreboard.
// Build with RAM_ARB_RR_EN defined to check the round-robin variant.

module tb_ram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [7:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_done, m1_gnt, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] mem       [0:255];
   logic [31:0] model_mem [0:255];

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] rdata;
      int          due;
   } sb_t;

   sb_t sb_q[$];
   bit  gnt_log[$];

   bit          acc_valid = 1'b0;
   int          acc_cyc = 0;
   bit          acc_we;
   logic [7:0]  acc_addr;
   logic [31:0] acc_wdata;

   ram_port_arbiter #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .MAX_WAIT  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m0_req),
      .m0_we    (m0_we),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_gnt   (m0_gnt),
      .m0_done  (m0_done),
      .m0_rdata (m0_rdata),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_gnt   (m1_gnt),
      .m1_done  (m1_done),
      .m1_rdata (m1_rdata),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: RAM-port timing, done/rdata against queued expectations, grant logging.
   always @(negedge clk) begin
      bit  exp_en;
      sb_t e;
      bit  wport;
      chk("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'd0);
      if (rst) chk("gnt_in_rst", 64'({m0_gnt, m1_gnt}), 64'd0);
      exp_en = acc_valid && (cyc == acc_cyc);
      chk("ram_en", 64'(ram_en), 64'(exp_en));
      if (exp_en) begin
         chk("ram_we", 64'(ram_we), 64'(acc_we));
         chk("ram_addr", 64'(ram_addr), 64'(acc_addr));
         if (acc_we) chk("ram_wdata", 64'(ram_wdata), 64'(acc_wdata));
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         chk("done_missing", 64'd0, 64'd1);
         void'(sb_q.pop_front());
      end
      if (m0_done || m1_done) begin
         if (sb_q.size() == 0) begin
            chk("done_spurious", 64'({m0_done, m1_done}), 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("done_port", 64'({m0_done, m1_done}), e.port ? 64'd1 : 64'd2);
            chk("done_cycle", 64'(cyc), 64'(e.due));
            if (!e.we) chk("rdata", 64'(e.port ? m1_rdata : m0_rdata), 64'(e.rdata));
         end
      end
      if (!rst && (m0_gnt || m1_gnt)) begin
         wport     = m1_gnt;
         acc_valid = 1'b1;
         acc_cyc   = cyc + 1;
         acc_we    = wport ? m1_we    : m0_we;
         acc_addr  = wport ? m1_addr  : m0_addr;
         acc_wdata = wport ? m1_wdata : m0_wdata;
         e.port    = wport;
         e.we      = acc_we;
         e.rdata   = model_mem[acc_addr];
         e.due     = cyc + 2;
         sb_q.push_back(e);
         gnt_log.push_back(wport);
         if (acc_we) model_mem[acc_addr] = acc_wdata;
      end
      if (rst) begin
         sb_q.delete();
         acc_valid = 1'b0;
      end
   end

   task automatic do_req(input bit port, input bit we, input logic [7:0] addr,
                         input logic [31:0] data);
      bit got;
      got = 1'b0;
      if (port) begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = data;
      end else begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = data;
      end
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = port ? m1_gnt : m0_gnt;
      end
      chk("gnt_timeout", 64'(got), 64'd1);
      @(posedge clk); #2;
      if (port) m1_req = 1'b0; else m0_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      bit got;
      bit exp_seq [10];
      for (int i = 0; i < 256; i++) begin
         mem[i]       = 32'h0;
         model_mem[i] = 32'h0;
      end
      mem[8'h02] = 32'h2412_0000; model_mem[8'h02] = 32'h2412_0000;
      mem[8'h10] = 32'h1111_0010; model_mem[8'h10] = 32'h1111_0010;
      mem[8'h11] = 32'h2222_0011; model_mem[8'h11] = 32'h2222_0011;

      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Idle after reset: everything stays zero.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ctrl", 64'({m0_gnt, m1_gnt, m0_done, m1_done, ram_en, ram_we}), 64'd0);
         chk("idle_ram", {ram_addr, ram_wdata}, 64'd0);
         chk("idle_rdata", {m0_rdata, m1_rdata}, 64'd0);
      end
      @(posedge clk); #2;

      // Port 0 write then read of the same address.
      do_req(1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
      do_req(1'b0, 1'b0, 8'h05, 32'h0);
      drain();

      // Port 1 read of preloaded word.
      do_req(1'b1, 1'b0, 8'h02, 32'h0);
      drain();

      // Both ports requesting continuously.
      gnt_log.delete();
      m0_we = 1'b0; m0_addr = 8'h10;
      m1_we = 1'b0; m1_addr = 8'h11;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 100 && gnt_log.size() < 10; i++) @(negedge clk);
      @(posedge clk); #2;
      m0_req = 1'b0; m1_req = 1'b0;
      chk("contend_count", 64'(gnt_log.size() >= 10), 64'd1);
      for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_RR_EN
         exp_seq[i] = (i % 2) == 1;
`else
         exp_seq[i] = (i == 4) || (i == 9);
`endif
         if (i < gnt_log.size()) chk($sformatf("contend_winner%0d", i),
                                     64'(gnt_log[i]), 64'(exp_seq[i]));
      end
      drain();

      // Reset during the ACCESS cycle of a read.
      m0_we = 1'b0; m0_addr = 8'h05; m0_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = m0_gnt;
      end
      chk("rst_gnt_timeout", 64'(got), 64'd1);
      @(posedge clk); #2;
      m0_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ctrl", 64'({m0_gnt, m1_gnt, m0_done, m1_done, ram_en, ram_we}), 64'd0);
      chk("rst_ram", {ram_addr, ram_wdata}, 64'd0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #2;

      // Normal service after reset; write then read returns new data.
      do_req(1'b1, 1'b1, 8'h05, 32'hCAFE_F00D);
      do_req(1'b0, 1'b0, 8'h05, 32'h0);
      drain();

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
